// File: rtl/tc_queue.sv
// -----------------------------------------------------------------------------
// tc_queue -- byte FIFO, the first-in-first-out counterpart of the LIFO stack.
//
// Bytes pushed at the tail leave from the head in arrival order. Provides
// occupancy, full/empty status and sticky overflow/underflow flags so a
// controller can pace transfers without overrunning the buffer.
//
// Parameters
//   WIDTH       data width in bits
//   DEPTH_LOG2  log2 of the entry count (DEPTH = 2**DEPTH_LOG2)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   push       enqueue `in` this cycle
//   pop        dequeue the head entry this cycle
//   in         write data, sampled on the push edge
//   out        registered read data, zero unless out_valid
//   out_valid  high for one cycle after an accepted pop
//   empty      occupancy is zero
//   full       occupancy is DEPTH
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: a push was rejected
//   underflow  sticky: a pop was rejected
// -----------------------------------------------------------------------------
module tc_queue #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      in,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   C_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] P_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [WIDTH-1:0]      r_out;
    logic                  r_out_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_pop_ok;
    logic                  w_push_ok;

    // A full queue still accepts a push when a pop frees the head slot in the
    // same cycle; an empty queue never forwards a same-cycle push to out.
    assign w_pop_ok  = pop & (r_count != '0);
    assign w_push_ok = push & ((r_count != C_DEPTH) | w_pop_ok);

    // Storage has no reset: entries are unobservable until written.
    always_ff @(posedge clk) begin
        if (w_push_ok && !rst) begin
            r_mem[r_wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_out       <= r_mem[r_rd_ptr];
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + P_ONE;
            end else begin
                r_out       <= '0;
                r_out_valid <= 1'b0;
            end

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
            end

            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + C_ONE;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - C_ONE;
            end

            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == C_DEPTH);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
